// File: rtl/chg_seq_pkg.sv
// Shared types and widths for the change-record sequencer.
//   chg_rec_t   : one buffered change.txt record {last, row, col, re, img}
//   chg_state_e : sequencer FSM states
package chg_seq_pkg;

  localparam int unsigned IDX_W = 16;
  localparam int unsigned VAL_W = 24;

  typedef struct packed {
    logic             last;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [VAL_W-1:0] re;
    logic [VAL_W-1:0] img;
  } chg_rec_t;

  localparam int unsigned REC_W = $bits(chg_rec_t);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } chg_state_e;

endpackage

// File: rtl/chg_record_sequencer_if.sv
// Record stream in, current record out, write-path completion back.
//   master : loader / write path side (drives in_*)
//   slave  : sequencer side (drives op_*)
interface chg_rec_if #(
  parameter int unsigned DEPTH = 8
);
  import chg_seq_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             in_recValid;
  logic [IDX_W-1:0] in_recRow;
  logic [IDX_W-1:0] in_recCol;
  logic [VAL_W-1:0] in_recReal;
  logic [VAL_W-1:0] in_recImg;
  logic             in_recLast;
  logic             op_recReady;
  logic [IDX_W-1:0] op_chgTxt_row;
  logic [IDX_W-1:0] op_chgTxt_col;
  logic [VAL_W-1:0] op_chgTxt_real;
  logic [VAL_W-1:0] op_chgTxt_img;
  logic             op_isDiag;
  logic             op_startUpdate;
  logic             in_updateDone;
  logic             op_busy;
  logic             op_allDone;
  logic [CNT_W-1:0] op_fifoCount;
  logic             op_rangeErr;

  modport master (
    output in_recValid, in_recRow, in_recCol, in_recReal, in_recImg, in_recLast,
    output in_updateDone,
    input  op_recReady, op_chgTxt_row, op_chgTxt_col, op_chgTxt_real, op_chgTxt_img,
    input  op_isDiag, op_startUpdate, op_busy, op_allDone, op_fifoCount, op_rangeErr
  );

  modport slave (
    input  in_recValid, in_recRow, in_recCol, in_recReal, in_recImg, in_recLast,
    input  in_updateDone,
    output op_recReady, op_chgTxt_row, op_chgTxt_col, op_chgTxt_real, op_chgTxt_img,
    output op_isDiag, op_startUpdate, op_busy, op_allDone, op_fifoCount, op_rangeErr
  );

endinterface

// File: rtl/chg_fifo.sv
// Synchronous FIFO with wrap-around pointers and occupancy count.
//   push_i/data_i : write (ignored when full)
//   pop_i/data_o  : head entry, removed on pop (ignored when empty)
//   count_o, full_o, empty_o : occupancy status
module chg_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/chg_record_sequencer.sv
// Buffers change.txt records and feeds them one at a time to the Y update
// path: start pulse per record, hold until done, sticky allDone after last.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   bus          : record input, current-record output, completion/status
module chg_record_sequencer
  import chg_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned N_MAX = 1024
) (
  input  logic     clock,
  input  logic     reset,
  chg_rec_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  chg_state_e       state_q, state_d;
  chg_rec_t         rec_q, rec_d;
  logic             diag_q, diag_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             all_q, all_d;
  logic             rerr_q, rerr_d;
  logic             pend_q, pend_d;

  chg_rec_t         wr_rec;
  chg_rec_t         head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             accept;
  logic             in_range;
  logic             push;
  logic             pop;

  assign accept   = bus.in_recValid && !full;
  assign in_range = (32'(bus.in_recRow) < N_MAX) && (32'(bus.in_recCol) < N_MAX);
  assign push     = accept && in_range;

  assign wr_rec = '{last: bus.in_recLast, row: bus.in_recRow, col: bus.in_recCol,
                    re: bus.in_recReal, img: bus.in_recImg};

  chg_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .data_i  (wr_rec),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rec_q   <= '0;
      diag_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      all_q   <= 1'b0;
      rerr_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      diag_q  <= diag_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      all_q   <= all_d;
      rerr_q  <= rerr_d;
      pend_q  <= pend_d;
    end
  end

  // Next state; a dropped last record still ends the stream via pend.
  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    diag_d  = diag_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    all_d   = all_q;
    rerr_d  = rerr_q || (accept && !in_range);
    pend_d  = pend_q || (accept && !in_range && bus.in_recLast);
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          rec_d   = head;
          diag_d  = (head.row == head.col);
          busy_d  = 1'b1;
          state_d = ST_LAUNCH;
        end else if (pend_q) begin
          all_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_LAUNCH: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.in_updateDone) begin
          busy_d = 1'b0;
          if (rec_q.last) begin
            all_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.op_recReady    = !full;
  assign bus.op_chgTxt_row  = rec_q.row;
  assign bus.op_chgTxt_col  = rec_q.col;
  assign bus.op_chgTxt_real = rec_q.re;
  assign bus.op_chgTxt_img  = rec_q.img;
  assign bus.op_isDiag      = diag_q;
  assign bus.op_startUpdate = start_q;
  assign bus.op_busy        = busy_q;
  assign bus.op_allDone     = all_q;
  assign bus.op_fifoCount   = count;
  assign bus.op_rangeErr    = rerr_q;

endmodule

// File: tb/tb_chg_record_sequencer.sv
// Directed bench for chg_record_sequencer.
module tb_chg_record_sequencer;
  import chg_seq_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  chg_rec_if #(.DEPTH(DEPTH)) bus ();

  chg_record_sequencer #(.DEPTH(DEPTH), .N_MAX(1024)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int starts = 0;
  logic [15:0] start_rows[$];

  // Log every start pulse with the row presented at that time.
  always @(posedge clock) begin
    if (reset === 1'b1 && bus.op_startUpdate === 1'b1) begin
      starts++;
      start_rows.push_back(bus.op_chgTxt_row);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int row, input int col, input int re, input int im, input bit last);
    int n;
    n = 0;
    bus.in_recValid = 1'b1;
    bus.in_recRow   = 16'(row);
    bus.in_recCol   = 16'(col);
    bus.in_recReal  = 24'(re);
    bus.in_recImg   = 24'(im);
    bus.in_recLast  = last;
    while (bus.op_recReady !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", 64'(bus.op_recReady), 64'd1);
    tick();
    bus.in_recValid = 1'b0;
    bus.in_recLast  = 1'b0;
  endtask

  task automatic pulse_done();
    bus.in_updateDone = 1'b1;
    tick();
    bus.in_updateDone = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (bus.op_startUpdate !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("start_seen", 64'(bus.op_startUpdate), 64'd1);
  endtask

  initial begin
    int s0;
    reset             = 1'b0;
    bus.in_recValid   = 1'b0;
    bus.in_recRow     = '0;
    bus.in_recCol     = '0;
    bus.in_recReal    = '0;
    bus.in_recImg     = '0;
    bus.in_recLast    = 1'b0;
    bus.in_updateDone = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Reset state
    chk("rst_ready", 64'(bus.op_recReady), 64'd1);
    chk("rst_count", 64'(bus.op_fifoCount), 64'd0);
    chk("rst_busy", 64'(bus.op_busy), 64'd0);
    chk("rst_alldone", 64'(bus.op_allDone), 64'd0);
    chk("rst_start", 64'(bus.op_startUpdate), 64'd0);
    chk("rst_rangeerr", 64'(bus.op_rangeErr), 64'd0);
    chk("rst_row", 64'(bus.op_chgTxt_row), 64'd0);

    // Done while idle and empty is ignored
    s0 = starts;
    pulse_done();
    tick();
    tick();
    chk("idle_done_busy", 64'(bus.op_busy), 64'd0);
    chk("idle_done_alldone", 64'(bus.op_allDone), 64'd0);
    chk("idle_done_starts", 64'(starts - s0), 64'd0);

    // Single diagonal record, latency and hold
    s0 = starts;
    push(3, 3, 24'h000100, 24'hFFFF00, 1'b1);
    tick();
    chk("single_t1_start", 64'(bus.op_startUpdate), 64'd0);
    chk("single_t1_busy", 64'(bus.op_busy), 64'd1);
    tick();
    chk("single_t2_start", 64'(bus.op_startUpdate), 64'd1);
    chk("single_diag", 64'(bus.op_isDiag), 64'd1);
    chk("single_row", 64'(bus.op_chgTxt_row), 64'd3);
    chk("single_col", 64'(bus.op_chgTxt_col), 64'd3);
    chk("single_real", 64'(bus.op_chgTxt_real), 64'h000100);
    chk("single_img", 64'(bus.op_chgTxt_img), 64'hFFFF00);
    tick();
    chk("single_t3_start", 64'(bus.op_startUpdate), 64'd0);
    repeat (5) tick();
    chk("single_hold_row", 64'(bus.op_chgTxt_row), 64'd3);
    chk("single_hold_busy", 64'(bus.op_busy), 64'd1);
    chk("single_hold_alldone", 64'(bus.op_allDone), 64'd0);
    pulse_done();
    chk("single_alldone", 64'(bus.op_allDone), 64'd1);
    chk("single_busy_end", 64'(bus.op_busy), 64'd0);
    chk("single_starts", 64'(starts - s0), 64'd1);
    chk("single_keep_row", 64'(bus.op_chgTxt_row), 64'd3);

    // Five records, launched in order one per done
    do_reset();
    s0 = starts;
    for (int i = 0; i < 5; i++) push(10 + i, 0, i, 0, (i == 4));
    repeat (3) tick();
    chk("five_count", 64'(bus.op_fifoCount), 64'd4);
    chk("five_one_start", 64'(starts - s0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("five_not_done_yet", 64'(bus.op_allDone), 64'd0);
      pulse_done();
      repeat (9) tick();
    end
    chk("five_starts", 64'(starts - s0), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("five_order", 64'(start_rows[s0 + i]), 64'(10 + i));
    chk("five_alldone", 64'(bus.op_allDone), 64'd1);
    chk("five_busy", 64'(bus.op_busy), 64'd0);

    // Fill to DEPTH with one record in flight, then stall
    do_reset();
    s0 = starts;
    for (int i = 0; i < 9; i++) push(20 + i, 1, 0, 0, 1'b0);
    chk("full_count", 64'(bus.op_fifoCount), 64'd8);
    chk("full_ready", 64'(bus.op_recReady), 64'd0);
    chk("full_busy", 64'(bus.op_busy), 64'd1);
    bus.in_recValid = 1'b1;
    bus.in_recRow   = 16'd29;
    bus.in_recCol   = 16'd1;
    repeat (3) tick();
    chk("stall_count", 64'(bus.op_fifoCount), 64'd8);
    chk("stall_ready", 64'(bus.op_recReady), 64'd0);
    pulse_done();
    chk("stall_done_count", 64'(bus.op_fifoCount), 64'd8);
    begin
      int n;
      n = 0;
      while (bus.op_recReady !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("stall_ready_again", 64'(bus.op_recReady), 64'd1);
    end
    tick();
    bus.in_recValid = 1'b0;
    chk("stall_refill_count", 64'(bus.op_fifoCount), 64'd8);
    repeat (3) tick();
    chk("stall_starts", 64'(starts - s0), 64'd2);
    chk("stall_second_row", 64'(start_rows[s0 + 1]), 64'd21);

    // Out-of-range record dropped between valid ones
    do_reset();
    s0 = starts;
    push(5, 6, 1, 1, 1'b0);
    push(2000, 1, 0, 0, 1'b0);
    push(7, 7, 2, 2, 1'b1);
    chk("range_err", 64'(bus.op_rangeErr), 64'd1);
    repeat (3) tick();
    chk("range_count", 64'(bus.op_fifoCount), 64'd1);
    pulse_done();
    repeat (5) tick();
    chk("range_starts", 64'(starts - s0), 64'd2);
    chk("range_row0", 64'(start_rows[s0]), 64'd5);
    chk("range_row1", 64'(start_rows[s0 + 1]), 64'd7);
    chk("range_diag", 64'(bus.op_isDiag), 64'd1);
    chk("range_not_done", 64'(bus.op_allDone), 64'd0);
    pulse_done();
    chk("range_alldone", 64'(bus.op_allDone), 64'd1);

    // Dropped record carrying last still ends the stream
    do_reset();
    s0 = starts;
    push(5000, 0, 0, 0, 1'b1);
    tick();
    chk("droplast_alldone", 64'(bus.op_allDone), 64'd1);
    chk("droplast_rangeerr", 64'(bus.op_rangeErr), 64'd1);
    chk("droplast_starts", 64'(starts - s0), 64'd0);

    // Reset while waiting with three records queued
    do_reset();
    for (int i = 0; i < 4; i++) push(40 + i, 2, 7, 7, 1'b0);
    repeat (2) tick();
    chk("midrst_pre_count", 64'(bus.op_fifoCount), 64'd3);
    chk("midrst_pre_busy", 64'(bus.op_busy), 64'd1);
    reset = 1'b0;
    tick();
    chk("midrst_count", 64'(bus.op_fifoCount), 64'd0);
    chk("midrst_ready", 64'(bus.op_recReady), 64'd1);
    chk("midrst_busy", 64'(bus.op_busy), 64'd0);
    chk("midrst_start", 64'(bus.op_startUpdate), 64'd0);
    chk("midrst_row", 64'(bus.op_chgTxt_row), 64'd0);
    chk("midrst_real", 64'(bus.op_chgTxt_real), 64'd0);
    chk("midrst_diag", 64'(bus.op_isDiag), 64'd0);
    reset = 1'b1;
    push(9, 9, 5, 5, 1'b1);
    wait_start();
    chk("midrst_new_row", 64'(bus.op_chgTxt_row), 64'd9);
    chk("midrst_new_diag", 64'(bus.op_isDiag), 64'd1);
    tick();
    pulse_done();
    chk("midrst_new_alldone", 64'(bus.op_allDone), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chg_record_sequencer.md
Name: chg_record_sequencer

Overview:
- Upstream feeder for updateYcomputation and busWriteY.
- Accepts change.txt records (row, col, real, img) from the loader or testbench and buffers them in a small FIFO.
- Presents one record at a time on stable outputs and pulses a start strobe.
- Holds that record until the write path reports completion, then advances. Flags completion after the record marked last has been written.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2)
- IDX_W, 16, row/col index width
- VAL_W, 24, real/imag component width
- N_MAX, 1024, buses in Y; a record with row or col >= N_MAX is out of range

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- in_recValid  in  1  upstream record valid
- in_recRow  in  IDX_W  change row index
- in_recCol  in  IDX_W  change column index
- in_recReal  in  VAL_W  change real part
- in_recImg  in  VAL_W  change imaginary part
- in_recLast  in  1  record is the final one of change.txt
- op_recReady  out  1  FIFO can accept a record
- op_chgTxt_row  out  IDX_W  current record row, to uYc_chgTxt_row
- op_chgTxt_col  out  IDX_W  current record column
- op_chgTxt_real  out  VAL_W  current record real part
- op_chgTxt_img  out  VAL_W  current record imaginary part
- op_isDiag  out  1  current row == col
- op_startUpdate  out  1  one-cycle start pulse for the current record
- in_updateDone  in  1  write-path completion pulse (busWriteY op_writeDone)
- op_busy  out  1  a record is in flight
- op_allDone  out  1  sticky; last record written
- op_fifoCount  out  log2(DEPTH)+1  FIFO occupancy
- op_rangeErr  out  1  sticky; an out-of-range record was dropped

Behaviour:
- Reset (reset==0 at a clock edge):
  - FIFO flushed, state IDLE.
  - All outputs 0, except op_recReady=1.
  - Reset mid-operation abandons the in-flight record; no done is expected afterwards.
- Push:
  - A record is accepted when in_recValid && op_recReady.
  - op_recReady = (count != DEPTH), combinational from count. A pop in the same cycle does not raise ready at full.
  - If row >= N_MAX or col >= N_MAX, the record is accepted (handshake completes) but not stored, and op_rangeErr is set.
  - A dropped record carrying in_recLast still marks end-of-stream: a last-pending flag is set so op_allDone rises once the FIFO drains and the in-flight record finishes.
- Stored entry: {last, row, col, real, img}. The FIFO uses wrap-around read/write pointers plus a count. Push and pop in the same cycle leave count unchanged.
- FSM:
  - IDLE: if count>0 and !op_allDone, pop the head into the output registers, compute op_isDiag, go to LAUNCH.
  - LAUNCH: op_startUpdate=1 for exactly this cycle, op_busy=1, go to WAIT.
  - WAIT: outputs held stable, op_busy=1. On in_updateDone:
    - if the entry's last bit is set → DONE;
    - otherwise → IDLE.
  - DONE: op_allDone=1 and op_busy=0. Stays here until reset. Further pushes are still accepted into the FIFO but never launched.
- in_updateDone seen in IDLE, LAUNCH or DONE is ignored.
- Latency:
  - Record pushed at edge t into an empty FIFO in IDLE → outputs valid and op_startUpdate high in the cycle after edge t+2.
  - in_updateDone at edge t with more records queued → next op_startUpdate after edge t+2.
- Output registers keep the last record after it completes; they are not cleared.

Decomposition:
- Package chg_seq_pkg holds:
  - the record struct {last, row, col, real, img};
  - the state enum {IDLE, LAUNCH, WAIT, DONE};
  - width constants IDX_W, VAL_W.
- One sub-module: chg_fifo, a synchronous FIFO with count and full/empty flags, parameterised by DEPTH and record width. The sequencer FSM and range check live in the top.

Test Plan:
- Single record (row 3, col 3, real 24'h000100, img 24'hFFFF00, last=1) → op_startUpdate once, op_isDiag=1, outputs stable until in_updateDone, then op_allDone=1 and op_busy=0.
- Five records, no done pulses → exactly one op_startUpdate. op_fifoCount reads 4 after the first launch. Five done pulses, spaced 10 cycles apart → five starts in push order, op_allDone after the fifth.
- Push 9 records at DEPTH=8 with the first held in WAIT → 8 stored plus 1 in flight. op_recReady=0 when count=8; the 10th record is stalled until a pop.
- Record row 2000 (>= N_MAX) between valid records → dropped, op_rangeErr=1, the neighbouring records are launched normally.
- in_updateDone pulsed while IDLE with FIFO empty → no state change, no start.
- Reset asserted in WAIT with 3 records queued → next cycle count=0, all outputs 0, op_recReady=1. A new record launches normally.
